// File: rtl/dest_reg_pipe_pkg.sv
// Shared types and helpers for the destination-register pipeline.
package dest_reg_pipe_pkg;

    // EX operand source select.
    typedef enum logic [1:0] {
        FwdNone = 2'b00,
        FwdMem  = 2'b01,
        FwdWb   = 2'b10
    } fwd_sel_e;

    // Select the EX operand source from the two in-flight producers.
    // A load in MEM cannot supply its data yet. The hazard stall keeps
    // that case from reaching EX. If it ever does, the older WB value
    // would be stale, so the regfile path is selected instead.
    function automatic fwd_sel_e fwd_select(
        input logic mem_hit,
        input logic mem_is_load,
        input logic wb_hit
    );
        fwd_sel_e sel;
        sel = FwdNone;
        if (mem_hit) begin
            if (!mem_is_load) begin
                sel = FwdMem;
            end
        end else if (wb_hit) begin
            sel = FwdWb;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// One pipeline stage holding an in-flight destination and its control bits.
// Source-register fields are kept only when HAS_SRC is set.
// When load_i is low, the stage takes a bubble (all fields zero).
module dest_stage_reg #(
    parameter int unsigned REG_W   = 5,
    parameter bit          HAS_SRC = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [REG_W-1:0] dest_i,
    input  logic             wr_i,
    input  logic             rd_mem_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             uses_rt_i,
    output logic             valid_o,
    output logic [REG_W-1:0] dest_o,
    output logic             wr_o,
    output logic             rd_mem_o,
    output logic [REG_W-1:0] rs_o,
    output logic [REG_W-1:0] rt_o,
    output logic             uses_rt_o
);

    logic             valid_d, valid_q;
    logic [REG_W-1:0] dest_d, dest_q;
    logic             wr_d, wr_q;
    logic             rd_mem_d, rd_mem_q;
    logic [REG_W-1:0] rs_d, rs_q;
    logic [REG_W-1:0] rt_d, rt_q;
    logic             uses_rt_d, uses_rt_q;

    // Next state: capture the upstream stage or insert a bubble.
    always_comb begin
        valid_d   = 1'b0;
        dest_d    = '0;
        wr_d      = 1'b0;
        rd_mem_d  = 1'b0;
        rs_d      = '0;
        rt_d      = '0;
        uses_rt_d = 1'b0;
        if (load_i) begin
            valid_d  = valid_i;
            dest_d   = dest_i;
            wr_d     = wr_i;
            rd_mem_d = rd_mem_i;
            if (HAS_SRC) begin
                rs_d      = rs_i;
                rt_d      = rt_i;
                uses_rt_d = uses_rt_i;
            end
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            dest_q    <= '0;
            wr_q      <= 1'b0;
            rd_mem_q  <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            uses_rt_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            dest_q    <= dest_d;
            wr_q      <= wr_d;
            rd_mem_q  <= rd_mem_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            uses_rt_q <= uses_rt_d;
        end
    end

    assign valid_o   = valid_q;
    assign dest_o    = dest_q;
    assign wr_o      = wr_q;
    assign rd_mem_o  = rd_mem_q;
    assign rs_o      = rs_q;
    assign rt_o      = rt_q;
    assign uses_rt_o = uses_rt_q;

endmodule

// File: rtl/dest_reg_pipe.sv
// Carries the ID-selected write register through EX/MEM/WB.
// Generates the load-use stall, the EX forwarding selects and the regfile write port.
module dest_reg_pipe
    import dest_reg_pipe_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             flush,
    output logic             load_use_stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [REG_W-1:0] ex_dest,
    output logic [REG_W-1:0] mem_dest,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_reg_write,
    output logic [CNT_W-1:0] stall_count
);

    logic             ex_load;
    logic             ex_valid, ex_wr, ex_rd_mem, ex_uses_rt;
    logic [REG_W-1:0] ex_rs, ex_rt;
    logic             mem_valid, mem_wr, mem_rd_mem;
    logic             wb_valid, wb_wr, wb_rd_mem;
    logic [REG_W-1:0] mem_rs, mem_rt, wb_rs, wb_rt;
    logic             mem_uses_rt, wb_uses_rt;
    logic             ex_wr_eff, mem_wr_eff, wb_wr_eff;
    logic             unused_tail;
    logic [CNT_W-1:0] stall_count_d, stall_count_q;

    // EX captures ID, or takes a bubble on stall/flush/empty ID.
    dest_stage_reg #(
        .REG_W   (REG_W),
        .HAS_SRC (1'b1)
    ) u_ex (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ex_load),
        .valid_i   (id_valid),
        .dest_i    (id_dest),
        .wr_i      (id_reg_write),
        .rd_mem_i  (id_mem_read),
        .rs_i      (id_rs),
        .rt_i      (id_rt),
        .uses_rt_i (id_uses_rt),
        .valid_o   (ex_valid),
        .dest_o    (ex_dest),
        .wr_o      (ex_wr),
        .rd_mem_o  (ex_rd_mem),
        .rs_o      (ex_rs),
        .rt_o      (ex_rt),
        .uses_rt_o (ex_uses_rt)
    );

    // MEM and WB advance every cycle; nothing downstream of ID can stall.
    dest_stage_reg #(
        .REG_W   (REG_W),
        .HAS_SRC (1'b0)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .load_i    (1'b1),
        .valid_i   (ex_valid),
        .dest_i    (ex_dest),
        .wr_i      (ex_wr),
        .rd_mem_i  (ex_rd_mem),
        .rs_i      ('0),
        .rt_i      ('0),
        .uses_rt_i (1'b0),
        .valid_o   (mem_valid),
        .dest_o    (mem_dest),
        .wr_o      (mem_wr),
        .rd_mem_o  (mem_rd_mem),
        .rs_o      (mem_rs),
        .rt_o      (mem_rt),
        .uses_rt_o (mem_uses_rt)
    );

    dest_stage_reg #(
        .REG_W   (REG_W),
        .HAS_SRC (1'b0)
    ) u_wb (
        .clk       (clk),
        .rst       (rst),
        .load_i    (1'b1),
        .valid_i   (mem_valid),
        .dest_i    (mem_dest),
        .wr_i      (mem_wr),
        .rd_mem_i  (mem_rd_mem),
        .rs_i      ('0),
        .rt_i      ('0),
        .uses_rt_i (1'b0),
        .valid_o   (wb_valid),
        .dest_o    (wb_dest),
        .wr_o      (wb_wr),
        .rd_mem_o  (wb_rd_mem),
        .rs_o      (wb_rs),
        .rt_o      (wb_rt),
        .uses_rt_o (wb_uses_rt)
    );

    // MEM/WB carry no source fields and WB never needs rd_mem.
    assign unused_tail = ^{mem_rs, mem_rt, mem_uses_rt, wb_rs, wb_rt, wb_uses_rt, wb_rd_mem};

    // Effective writes: register 0 is hard-wired, so a write to it is ignored everywhere.
    always_comb begin
        ex_wr_eff  = ex_valid & ex_wr & (ex_dest != '0);
        mem_wr_eff = mem_valid & mem_wr & (mem_dest != '0);
        wb_wr_eff  = wb_valid & wb_wr & (wb_dest != '0);
    end

    // Load-use hazard detection; a flush kills the consumer, so it wins over the stall.
    always_comb begin
        load_use_stall = id_valid & ~flush & ex_rd_mem & ex_wr_eff &
                         ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
        ex_load        = id_valid & ~flush & ~load_use_stall;
    end

    // Forwarding selects for the instruction in EX; MEM is newer than WB.
    always_comb begin
        fwd_a = fwd_select(mem_wr_eff & (mem_dest == ex_rs), mem_rd_mem,
                           wb_wr_eff & (wb_dest == ex_rs));
        fwd_b = FwdNone;
        if (ex_uses_rt) begin
            fwd_b = fwd_select(mem_wr_eff & (mem_dest == ex_rt), mem_rd_mem,
                               wb_wr_eff & (wb_dest == ex_rt));
        end
    end

    assign wb_reg_write = wb_wr_eff;

    // Stall counter next state, saturating at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        if (load_use_stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe. A second instance with a narrow counter
// shares the stimulus so counter saturation is reachable in a short run.
module tb_dest_reg_pipe;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       flush;

    logic        load_use_stall;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  ex_dest, mem_dest, wb_dest;
    logic        wb_reg_write;
    logic [15:0] stall_count;

    logic        s_load_use_stall;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [4:0]  s_ex_dest, s_mem_dest, s_wb_dest;
    logic        s_wb_reg_write;
    logic [3:0]  s_stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    dest_reg_pipe #(
        .REG_W (5),
        .CNT_W (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_dest        (id_dest),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .flush          (flush),
        .load_use_stall (load_use_stall),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .ex_dest        (ex_dest),
        .mem_dest       (mem_dest),
        .wb_dest        (wb_dest),
        .wb_reg_write   (wb_reg_write),
        .stall_count    (stall_count)
    );

    dest_reg_pipe #(
        .REG_W (5),
        .CNT_W (4)
    ) dut_small (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_dest        (id_dest),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .flush          (flush),
        .load_use_stall (s_load_use_stall),
        .fwd_a          (s_fwd_a),
        .fwd_b          (s_fwd_b),
        .ex_dest        (s_ex_dest),
        .mem_dest       (s_mem_dest),
        .wb_dest        (s_wb_dest),
        .wb_reg_write   (s_wb_reg_write),
        .stall_count    (s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] d, input logic wr, input logic mr,
                          input logic [4:0] rs, input logic [4:0] rt, input logic urt);
        id_valid     = v;
        id_dest      = d;
        id_reg_write = wr;
        id_mem_read  = mr;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        nop();

        // 1. reset, then a plain write emerges at WB three edges later
        tick();
        tick();
        chk("rst_stall", load_use_stall, 0);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_ex_dest", ex_dest, 0);
        chk("rst_mem_dest", mem_dest, 0);
        chk("rst_wb_dest", wb_dest, 0);
        chk("rst_wb_we", wb_reg_write, 0);
        chk("rst_count", stall_count, 0);
        rst = 1'b0;
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("t1_ex_dest", ex_dest, 8);
        nop();
        tick();
        chk("t1_mem_dest", mem_dest, 8);
        chk("t1_wb_we_early", wb_reg_write, 0);
        tick();
        chk("t1_wb_dest", wb_dest, 8);
        chk("t1_wb_we", wb_reg_write, 1);

        // 2. lw $9 followed by a consumer of $9
        set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd9, 5'd2, 1'b1);
        chk("t2_stall", load_use_stall, 1);
        tick();
        chk("t2_stall_one_cycle", load_use_stall, 0);
        chk("t2_ex_bubble", ex_dest, 0);
        chk("t2_count", stall_count, 1);
        chk("t2_count_small", s_stall_count, 1);
        tick();
        chk("t2_ex_dest", ex_dest, 10);
        chk("t2_fwd_a", fwd_a, 2'b10);
        chk("t2_fwd_b", fwd_b, 2'b00);
        nop();

        // 3. back-to-back dependency forwards from MEM, one gap forwards from WB
        tick();
        tick();
        tick();
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1);
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 1'b1);
        chk("t3_no_stall", load_use_stall, 0);
        tick();
        chk("t3_mem_fwd_a", fwd_a, 2'b01);
        chk("t3_mem_fwd_b", fwd_b, 2'b01);
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1);
        tick();
        nop();
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 1'b1);
        tick();
        chk("t3_wb_fwd_a", fwd_a, 2'b10);
        chk("t3_wb_fwd_b", fwd_b, 2'b10);

        // 4. same destination in MEM and WB: MEM wins; writes to $0 are ignored
        set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        set_id(1'b1, 5'd11, 1'b0, 1'b0, 5'd7, 5'd7, 1'b0);
        tick();
        chk("t4_prio_fwd_a", fwd_a, 2'b01);
        chk("t4_no_rt_fwd_b", fwd_b, 2'b00);
        set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd3, 5'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd11, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
        tick();
        chk("t4_zero_fwd_a", fwd_a, 2'b00);
        chk("t4_zero_fwd_b", fwd_b, 2'b00);
        nop();
        tick();
        chk("t4_zero_wb_dest", wb_dest, 0);
        chk("t4_zero_wb_we", wb_reg_write, 0);
        tick();

        // 5. flush beats the hazard; then saturation of the counter
        set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);
        tick();
        flush = 1'b1;
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd9, 5'd0, 1'b0);
        chk("t5_flush_stall", load_use_stall, 0);
        tick();
        chk("t5_flush_bubble", ex_dest, 0);
        chk("t5_flush_count", stall_count, 1);
        flush = 1'b0;
        nop();
        tick();
        tick();
        // A self-dependent load stalls on every other edge: 40 edges -> 20 stalls
        set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 5'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        nop();
        chk("t5_count_21", stall_count, 21);
        chk("t5_small_sat", s_stall_count, 4'hF);
        chk("t5_small_sat_stall_seen", s_load_use_stall, 0);

        // 6. reset with three writes in flight
        tick();
        tick();
        tick();
        set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd14, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("t6_pre_wb_we", wb_reg_write, 1);
        chk("t6_pre_wb_dest", wb_dest, 12);
        nop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_wb_we", wb_reg_write, 0);
        chk("t6_ex_dest", ex_dest, 0);
        chk("t6_mem_dest", mem_dest, 0);
        chk("t6_wb_dest", wb_dest, 0);
        chk("t6_count", stall_count, 0);
        set_id(1'b1, 5'd15, 1'b0, 1'b0, 5'd12, 5'd13, 1'b1);
        tick();
        chk("t6_fwd_a", fwd_a, 2'b00);
        chk("t6_fwd_b", fwd_b, 2'b00);
        nop();
        tick();
        chk("t6_wb_we_after", wb_reg_write, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
